ysyx_25040111_ifu: RTL and testbench

- Instruction fetch unit for the NPC core; sits directly upstream of the IDU.
- Owns the PC and issues one 32-bit fetch at a time to instruction memory over a simple req/resp handshake.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents them to the IDU with valid/ready.
- Accepts single-cycle redirects (branch/jump dnpc) from EXU and flushes in-flight and buffered work.

---
 rtl/ysyx_25040111_ifu_pkg.sv | 19 +
 rtl/ysyx_25040111_ifu_fifo.sv | 53 +++++
 rtl/ysyx_25040111_ifu.sv | 125 ++++++++++++
 tb/tb_ysyx_25040111_ifu.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_ifu_pkg.sv
// Shared types and constants for the NPC instruction fetch unit.
// Holds the FSM encoding, the reset PC default and the buffered {pc, inst} entry layout.
package ysyx_25040111_ifu_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_25040111_ifu_fifo.sv
// Small synchronous FIFO of {pc, inst} entries between the fetch FSM and the IDU.
// Flush has priority over push and pop; DEPTH must be a power of two, at least 2.
module ysyx_25040111_ifu_fifo
    import ysyx_25040111_ifu_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !flush && (count != CW'(DEPTH));
    assign do_pop  = pop && !flush && (count != '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ysyx_25040111_ifu.sv
// NPC instruction fetch unit: owns the PC, one outstanding imem fetch, FIFO toward the IDU.
// Optional YSYX_25040111_IFU_MISALIGN_EN adds fetch_fault and parks on misaligned redirects.
module ysyx_25040111_ifu
    import ysyx_25040111_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [INST_W-1:0] out_inst
`ifdef YSYX_25040111_IFU_MISALIGN_EN
    ,
    output logic              fetch_fault
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q;
    logic          drop_q, drop_d;
    logic [31:0]   target_pc;
    logic          park;
    logic          push, pop, room;
    logic [CW-1:0] count, cnt_after;
    fetch_entry_t  head;

`ifdef YSYX_25040111_IFU_MISALIGN_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fault_q <= 1'b0;
        else if (redirect_valid) fault_q <= (redirect_pc[1:0] != 2'b00);
    end

    assign park        = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault_q;
    assign target_pc   = redirect_pc;
    assign fetch_fault = fault_q;
`else
    logic unused_pc_lsb;

    assign park          = 1'b0;
    assign target_pc     = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsb = ^redirect_pc[1:0];
`endif

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = (state_q == IFU_WAIT) && imem_resp_valid && !drop_q && !redirect_valid;
    // Occupancy after this cycle's push/pop, ignoring a redirect (which empties the FIFO).
    assign cnt_after = count + CW'(push) - CW'(pop);
    assign room      = cnt_after < CW'(FIFO_DEPTH);

    ysyx_25040111_ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ('{pc: req_addr_q, inst: imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        pc_d    = pc_q;
        case (state_q)
            IFU_IDLE: begin
                if (redirect_valid || room) state_d = IFU_REQ;
            end
            IFU_REQ: begin
                if (imem_req_ready) state_d = IFU_WAIT;
                if (redirect_valid) drop_d  = 1'b1;
            end
            IFU_WAIT: begin
                if (imem_resp_valid) begin
                    drop_d = 1'b0;
                    if (!drop_q) pc_d = req_addr_q + 32'd4;
                    state_d = (redirect_valid || room) ? IFU_REQ : IFU_IDLE;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
        if (redirect_valid) pc_d = target_pc;
        // A request already on the bus must complete; only new requests are suppressed on a fault.
        if (park && state_d == IFU_REQ && state_q != IFU_REQ) state_d = IFU_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IFU_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (state_d == IFU_REQ && state_q != IFU_REQ) req_addr_q <= pc_d;
        end
    end

    assign imem_req_valid = rst_n && (state_q == IFU_REQ);
    assign imem_addr      = req_addr_q;
    assign out_pc         = out_valid ? head.pc : '0;
    assign out_inst       = out_valid ? head.inst : '0;

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// Self-checking bench for ysyx_25040111_ifu: cycle table for the fetch stream, then
// directed sequences for stall, redirect/drop, bus-hold and (optionally) misaligned redirects.
module tb_ysyx_25040111_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef YSYX_25040111_IFU_MISALIGN_EN
    logic        fetch_fault;
`endif

    ysyx_25040111_ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst)
`ifdef YSYX_25040111_IFU_MISALIGN_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h8010_0093;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- memory model ----------------
    int          resp_delay  = 1;
    int          stall_token = 0;
    int          proto_viol  = 0;

    initial begin
        logic        pending   = 1'b0;
        logic        prev_wait = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [31:0] pend_addr = '0;
        int          resp_cnt  = 0;
        int          stall_cnt = 0;
        int          seen_tok  = 0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_rdata      = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending         = 1'b0;
                prev_wait       = 1'b0;
                imem_resp_valid = 1'b0;
                imem_req_ready  = 1'b0;
            end else begin
                imem_resp_valid = 1'b0;
                if (pending) begin
                    if (resp_cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_rdata      = inst_of(pend_addr);
                        pending         = 1'b0;
                    end else begin
                        resp_cnt--;
                    end
                end
                if (prev_wait && !(imem_req_valid && imem_addr == prev_addr)) proto_viol++;
                if (imem_req_valid && pending) proto_viol++;
                if (stall_token != seen_tok) begin
                    seen_tok  = stall_token;
                    stall_cnt = 4;
                end
                if (stall_cnt > 0) begin
                    imem_req_ready = 1'b0;
                    stall_cnt--;
                end else begin
                    imem_req_ready = 1'b1;
                end
                if (imem_req_valid && imem_req_ready) begin
                    pending   = 1'b1;
                    pend_addr = imem_addr;
                    resp_cnt  = resp_delay - 1;
                end
                prev_wait = imem_req_valid && !imem_req_ready;
                prev_addr = imem_addr;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic expect_stream(input string nm, input logic [31:0] start, input int n);
        logic [31:0] exp;
        exp       = start;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            while (!out_valid && w < 60) begin
                tick();
                w++;
            end
            check({nm, "_arrive"}, 32'(w < 60), 32'd1);
            check({nm, "_pc"}, out_pc, exp);
            check({nm, "_inst"}, out_inst, inst_of(exp));
            exp = exp + 32'd4;
            tick();
        end
    endtask

    task automatic wait_accept(input string nm);
        int w;
        w = 0;
        while (!(imem_req_valid && imem_req_ready) && w < 60) begin
            tick();
            w++;
        end
        check(nm, 32'(w < 60), 32'd1);
    endtask

    task automatic wait_req(input string nm);
        int w;
        w = 0;
        while (!imem_req_valid && w < 60) begin
            tick();
            w++;
        end
        check(nm, 32'(w < 60), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic        rdy;      // out_ready applied after the check
        logic        exp_ov;
        logic [31:0] exp_pc;
        logic        exp_rv;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int          w;
        int          reqs;
        logic [31:0] held;

        tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0000};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0004};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0008};
        tbl[5]  = '{1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_000C};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0010};

        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
`ifdef YSYX_25040111_IFU_MISALIGN_EN
        check("rst_fault", 32'(fetch_fault), 32'd0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Cycle-exact fetch stream, including a 4-cycle IDU stall that fills the FIFO.
        for (int k = 0; k < 11; k++) begin
            tick();
            check($sformatf("t%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].exp_ov));
            if (tbl[k].exp_ov) begin
                check($sformatf("t%0d_out_pc", k), out_pc, tbl[k].exp_pc);
                check($sformatf("t%0d_out_inst", k), out_inst, inst_of(tbl[k].exp_pc));
            end
            check($sformatf("t%0d_req_valid", k), 32'(imem_req_valid), 32'(tbl[k].exp_rv));
            if (tbl[k].exp_rv) check($sformatf("t%0d_addr", k), imem_addr, tbl[k].exp_addr);
            out_ready = tbl[k].rdy;
        end

        // Long IDU stall: two entries buffered, fetch stops, then drains in order.
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2 && imem_req_valid) reqs++;
        end
        check("stall_no_req", 32'(reqs), 32'd0);
        check("stall_head_pc", out_pc, 32'h8000_000C);
        expect_stream("stall_drain", 32'h8000_000C, 4);

        // Redirect while WAIT, response arrives 3 cycles after accept and must be dropped.
        out_ready  = 1'b0;
        resp_delay = 3;
        wait_accept("wait_accept_s3");
        tick();
        pulse_redirect(32'h8000_0100);
        check("s3_flushed", 32'(out_valid), 32'd0);
        expect_stream("s3_after_drop", 32'h8000_0100, 2);
        resp_delay = 1;

        // Redirect coinciding with resp and a pop while one entry is buffered.
        out_ready = 1'b0;
        pulse_redirect(32'h8000_0300);
        w = 0;
        while (!(imem_resp_valid && out_valid) && w < 60) begin
            tick();
            w++;
        end
        check("s4_found", 32'(w < 60), 32'd1);
        check("s4_head_pc", out_pc, 32'h8000_0300);
        out_ready = 1'b1;
        pulse_redirect(32'h8000_0400);
        out_ready = 1'b0;
        check("s4_flushed", 32'(out_valid), 32'd0);
        check("s4_req_valid", 32'(imem_req_valid), 32'd1);
        check("s4_req_addr", imem_addr, 32'h8000_0400);
        tick();
        check("s4_no_bypass", 32'(out_valid), 32'd0);
        tick();
        check("s4_out_valid", 32'(out_valid), 32'd1);
        check("s4_out_pc", out_pc, 32'h8000_0400);
        check("s4_out_inst", out_inst, inst_of(32'h8000_0400));

        // Memory not ready for 4 cycles, redirect while the request is held on the bus.
        out_ready = 1'b1;
        stall_token++;
        w = 0;
        while (!(imem_req_valid && !imem_req_ready) && w < 60) begin
            tick();
            w++;
        end
        check("s5_stalled_req", 32'(w < 60), 32'd1);
        held = imem_addr;
        tick();
        pulse_redirect(32'h8000_0800);
        wait_accept("s5_accept");
        check("s5_held_addr", imem_addr, held);
        tick();
        wait_req("s5_next_req");
        check("s5_target_addr", imem_addr, 32'h8000_0800);
        expect_stream("s5_after_drop", 32'h8000_0800, 1);

        // Misaligned redirect.
        pulse_redirect(32'h8000_0102);
`ifdef YSYX_25040111_IFU_MISALIGN_EN
        check("s6_fault_set", 32'(fetch_fault), 32'd1);
        repeat (8) tick();
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (imem_req_valid) reqs++;
        end
        check("s6_parked", 32'(reqs), 32'd0);
        check("s6_no_out", 32'(out_valid), 32'd0);
        pulse_redirect(32'h8000_0200);
        check("s6_fault_clr", 32'(fetch_fault), 32'd0);
        check("s6_req_valid", 32'(imem_req_valid), 32'd1);
        check("s6_req_addr", imem_addr, 32'h8000_0200);
        expect_stream("s6_resume", 32'h8000_0200, 1);
`else
        expect_stream("s6_aligned", 32'h8000_0100, 2);
`endif

        // Asynchronous reset with buffered entries.
        out_ready = 1'b0;
        repeat (8) tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_pc", out_pc, 32'd0);
        check("arst_out_inst", out_inst, 32'd0);

        check("bus_protocol", 32'(proto_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
